// File: rtl/apm_meas_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apm_meas_pkg
// Brief    : Shared types and helpers for the APM measurement controller.
// Revision : 1.0 - initial release
// ============================================================================
package apm_meas_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        WARM    = 3'd2,
        MEASURE = 3'd3,
        DONE    = 3'd4
    } apm_meas_state_e;

    typedef struct packed {
        logic       cal;
        logic       step;
        logic       osc_sel;
        logic [1:0] xtor_sel;
        logic [3:0] mux_sel;
        logic [3:0] vdac_sel;
    } apm_cfg_t;

    function automatic int apm_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : apm_meas_pkg
`default_nettype wire

// File: rtl/apm_meas_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apm_meas_ctrl_if
// Brief    : Request/response handshake bundle of the APM measurement controller.
// Revision : 1.0 - initial release
// ============================================================================
interface apm_meas_ctrl_if #(
    parameter int WIN_W = 16,
    parameter int CNT_W = 16
) ();
    logic             req_valid;
    logic             req_ready;
    logic             req_cal;
    logic             req_step;
    logic             req_osc_sel;
    logic [1:0]       req_xtor_sel;
    logic [3:0]       req_mux_sel;
    logic [3:0]       req_vdac_sel;
    logic [WIN_W-1:0] req_win;
    logic             abort;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [CNT_W-1:0] rsp_count;
    logic             rsp_sat;
    logic             rsp_abort;
    logic             busy;

    modport master (
        output req_valid, req_cal, req_step, req_osc_sel, req_xtor_sel,
               req_mux_sel, req_vdac_sel, req_win, abort, rsp_ready,
        input  req_ready, rsp_valid, rsp_count, rsp_sat, rsp_abort, busy
    );

    modport slave (
        input  req_valid, req_cal, req_step, req_osc_sel, req_xtor_sel,
               req_mux_sel, req_vdac_sel, req_win, abort, rsp_ready,
        output req_ready, rsp_valid, rsp_count, rsp_sat, rsp_abort, busy
    );
endinterface : apm_meas_ctrl_if
`default_nettype wire

// File: rtl/apm_osc_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apm_sync / apm_osc_sync_edge
// Brief    : Multi-flop synchronizer, and a variant adding a rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module apm_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_b,
    input  logic async_in,
    output logic sync_out
);
    logic [SYNC_STG-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], async_in};
        end
    end

    assign sync_out = r_sync[SYNC_STG-1];
endmodule : apm_sync

module apm_osc_sync_edge #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_b,
    input  logic async_in,
    output logic rise
);
    logic w_sync;
    logic r_prev;

    apm_sync #(.SYNC_STG(SYNC_STG)) u_sync (
        .clk      (clk),
        .rst_b    (rst_b),
        .async_in (async_in),
        .sync_out (w_sync)
    );

    // Free-running history flop: no spurious edge when a window opens.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_sync;
        end
    end

    assign rise = w_sync & ~r_prev;
endmodule : apm_osc_sync_edge
`default_nettype wire

// File: rtl/apm_meas_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apm_meas_ctrl
// Brief    : Sequences APM HIP enables/selects and counts oscillator edges.
// Revision : 1.0 - initial release
// ============================================================================
module apm_meas_ctrl
    import apm_meas_pkg::*;
#(
    parameter int SETTLE_CYC = 64,
    parameter int WARM_CYC   = 16,
    parameter int WIN_W      = 16,
    parameter int CNT_W      = 16,
    parameter int SYNC_STG   = 2
) (
    input  logic            clk,
    input  logic            rst_b,
    apm_meas_ctrl_if.slave  bus,
    output logic            apm_en_cal,
    output logic            apm_en_osc,
    output logic            apm_en_sensor,
    output logic            apm_en_step,
    output logic            apm_osc_sel,
    output logic [1:0]      apm_xtor_sel,
    output logic [3:0]      apm_mux_sel,
    output logic [3:0]      apm_vdac_sel,
    input  logic            apm_osc_out,
    input  logic            apm_debug_out,
    output logic            dbg_sync
);
    localparam int c_TMR_W = apm_max(WIN_W,
                             apm_max($clog2(SETTLE_CYC + 1), $clog2(WARM_CYC + 1)));
    localparam logic [c_TMR_W-1:0] c_SETTLE_LD = c_TMR_W'(SETTLE_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_WARM_LD   = c_TMR_W'(WARM_CYC - 1);

    apm_meas_state_e    r_state;
    apm_cfg_t           r_cfg;
    logic [WIN_W-1:0]   r_win;
    logic [c_TMR_W-1:0] r_timer;
    logic [CNT_W-1:0]   r_count;
    logic               r_sat;
    logic               r_abort;
    logic               r_rsp_valid;
    logic               r_req_ready;
    logic               r_busy;
    logic               r_en_cal;
    logic               r_en_osc;
    logic               r_en_sensor;
    logic               r_en_step;

    logic               w_osc_rise;
    logic               w_run;
    logic               w_timer_zero;
    logic [c_TMR_W-1:0] w_meas_ld;

    apm_osc_sync_edge #(.SYNC_STG(SYNC_STG)) u_osc_edge (
        .clk      (clk),
        .rst_b    (rst_b),
        .async_in (apm_osc_out),
        .rise     (w_osc_rise)
    );

    apm_sync #(.SYNC_STG(SYNC_STG)) u_dbg_sync (
        .clk      (clk),
        .rst_b    (rst_b),
        .async_in (apm_debug_out),
        .sync_out (dbg_sync)
    );

    assign w_run        = (r_state == SETTLE) || (r_state == WARM) || (r_state == MEASURE);
    assign w_timer_zero = (r_timer == '0);
    // A zero-length window still measures for one cycle.
    assign w_meas_ld    = (r_win == '0) ? '0 : c_TMR_W'(r_win - 1'b1);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= IDLE;
            r_cfg       <= '0;
            r_win       <= '0;
            r_timer     <= '0;
            r_count     <= '0;
            r_sat       <= 1'b0;
            r_abort     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_en_cal    <= 1'b0;
            r_en_osc    <= 1'b0;
            r_en_sensor <= 1'b0;
            r_en_step   <= 1'b0;
        end else begin
            if (w_run && bus.abort) begin
                r_state     <= DONE;
                r_abort     <= 1'b1;
                r_rsp_valid <= 1'b1;
                r_en_cal    <= 1'b0;
                r_en_osc    <= 1'b0;
                r_en_sensor <= 1'b0;
                r_en_step   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.req_valid && r_req_ready) begin
                            r_state        <= SETTLE;
                            r_req_ready    <= 1'b0;
                            r_busy         <= 1'b1;
                            r_cfg.cal      <= bus.req_cal;
                            r_cfg.step     <= bus.req_step;
                            r_cfg.osc_sel  <= bus.req_osc_sel;
                            r_cfg.xtor_sel <= bus.req_xtor_sel;
                            r_cfg.mux_sel  <= bus.req_mux_sel;
                            r_cfg.vdac_sel <= bus.req_vdac_sel;
                            r_win          <= bus.req_win;
                            r_timer        <= c_SETTLE_LD;
                            r_count        <= '0;
                            r_sat          <= 1'b0;
                            r_abort        <= 1'b0;
                            r_en_sensor    <= 1'b1;
                            r_en_cal       <= bus.req_cal;
                        end else begin
                            r_req_ready <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (w_timer_zero) begin
                            r_state   <= WARM;
                            r_timer   <= c_WARM_LD;
                            r_en_osc  <= 1'b1;
                            r_en_step <= r_cfg.step;
                            r_en_cal  <= r_cfg.cal;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    WARM: begin
                        if (w_timer_zero) begin
                            r_state <= MEASURE;
                            r_timer <= w_meas_ld;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    MEASURE: begin
                        if (w_timer_zero) begin
                            r_state     <= DONE;
                            r_rsp_valid <= 1'b1;
                            r_en_cal    <= 1'b0;
                            r_en_osc    <= 1'b0;
                            r_en_sensor <= 1'b0;
                            r_en_step   <= 1'b0;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    DONE: begin
                        if (bus.rsp_ready) begin
                            r_state     <= IDLE;
                            r_rsp_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_req_ready <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end

            // Edges in the aborting cycle still count toward the partial result.
            if ((r_state == MEASURE) && w_osc_rise) begin
                if (&r_count) begin
                    r_sat <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_count = r_count;
    assign bus.rsp_sat   = r_sat;
    assign bus.rsp_abort = r_abort;
    assign bus.busy      = r_busy;

    assign apm_en_cal    = r_en_cal;
    assign apm_en_osc    = r_en_osc;
    assign apm_en_sensor = r_en_sensor;
    assign apm_en_step   = r_en_step;
    assign apm_osc_sel   = r_cfg.osc_sel;
    assign apm_xtor_sel  = r_cfg.xtor_sel;
    assign apm_mux_sel   = r_cfg.mux_sel;
    assign apm_vdac_sel  = r_cfg.vdac_sel;
endmodule : apm_meas_ctrl
`default_nettype wire
